// File: rtl/fifo_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// fifo_write_arbiter_if
// Groups the requester streams and the FIFO write side that pass through
// fifo_write_arbiter.
//   req_valid/req_last/req_data : per-requester stream (requester i uses
//                                 req_data[i*DSIZE +: DSIZE])
//   req_ready                   : per-requester ready, one-hot or zero
//   wfull                       : FIFO full flag (write domain)
//   winc/wdata                  : FIFO write enable and data
// Modports: master = requesters + FIFO model, slave = arbiter.
// -----------------------------------------------------------------------------
interface fifo_write_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_last;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  wfull;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;

  modport master (
    output req_valid, req_last, req_data, wfull,
    input  req_ready, winc, wdata
  );

  modport slave (
    input  req_valid, req_last, req_data, wfull,
    output req_ready, winc, wdata
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_write_arbiter
// Round-robin arbiter sharing the write port of an async FIFO among NREQ
// valid/ready requesters. Runs entirely in the write clock domain.
// A winner keeps the port until its last beat or MAX_BURST beats, then the
// arbiter returns to IDLE for one cycle (which is also the arbitration cycle).
// Ports:
//   wclk       : write-domain clock
//   wrst       : asynchronous active-low reset
//   bus        : requester streams + FIFO write side (slave modport)
//   grant_id   : current owner, valid while busy=1
//   busy       : high while a requester owns the port
//   xfer_count : total beats written, wraps modulo 2^CWIDTH
// -----------------------------------------------------------------------------
module fifo_write_arbiter #(
  parameter int NREQ      = 4,
  parameter int DSIZE     = 8,
  parameter int MAX_BURST = 4,
  parameter int CWIDTH    = 16
) (
  input  logic                    wclk,
  input  logic                    wrst,
  fifo_write_arbiter_if.slave     bus,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy,
  output logic [CWIDTH-1:0]       xfer_count
);
  localparam int IW = $clog2(NREQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t            state_reg, state_next;
  logic [IW-1:0]     grant_reg, grant_next;
  logic [IW-1:0]     last_owner_reg, last_owner_next;
  logic [BW-1:0]     beat_cnt_reg, beat_cnt_next;
  logic [CWIDTH-1:0] xfer_count_reg, xfer_count_next;

  logic [DSIZE-1:0]  data_slice [NREQ];
  logic [IW-1:0]     winner;
  logic [IW-1:0]     cand;
  logic              winner_found;
  int                idx;
  logic              beat;
  logic              burst_done;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
      assign data_slice[gi] = bus.req_data[gi*DSIZE +: DSIZE];
    end
  endgenerate

  // Round-robin search: first valid requester after last_owner, with wrap.
  always_comb begin
    winner       = '0;
    winner_found = 1'b0;
    idx          = 0;
    cand         = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last_owner_reg) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = IW'(idx);
      if (!winner_found && bus.req_valid[cand]) begin
        winner       = cand;
        winner_found = 1'b1;
      end
    end
  end

  assign beat       = bus.winc;
  assign burst_done = bus.req_last[grant_reg] |
                      (beat_cnt_reg == BW'(MAX_BURST - 1));

  // State register
  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      last_owner_reg <= IW'(NREQ - 1);
      beat_cnt_reg   <= '0;
      xfer_count_reg <= '0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_owner_reg <= last_owner_next;
      beat_cnt_reg   <= beat_cnt_next;
      xfer_count_reg <= xfer_count_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_owner_next = last_owner_reg;
    beat_cnt_next   = beat_cnt_reg;
    xfer_count_next = xfer_count_reg;
    if (beat) xfer_count_next = xfer_count_reg + CWIDTH'(1);
    case (state_reg)
      IDLE: begin
        // wfull deliberately does not gate the grant.
        if (winner_found) begin
          state_next = GRANT;
          grant_next = winner;
        end
      end
      GRANT: begin
        if (beat) begin
          if (burst_done) begin
            state_next      = IDLE;
            last_owner_next = grant_reg;
            beat_cnt_next   = '0;
          end else begin
            beat_cnt_next = beat_cnt_reg + BW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs: combinational from the registered owner.
  always_comb begin
    busy          = 1'b0;
    bus.winc      = 1'b0;
    bus.req_ready = '0;
    bus.wdata     = '0;
    if (state_reg == GRANT) begin
      busy                     = 1'b1;
      bus.req_ready[grant_reg] = !bus.wfull;
      bus.winc                 = bus.req_valid[grant_reg] & !bus.wfull;
      bus.wdata                = data_slice[grant_reg];
    end
  end

  assign grant_id   = grant_reg;
  assign xfer_count = xfer_count_reg;
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_write_arbiter
// Scoreboard bench: per-requester source queues feed the DUT; the expected
// service order (owner, data) is pushed when stimulus is loaded and popped by
// a monitor on every winc. A second instance with CWIDTH=4 shares the inputs
// to exercise counter wrap.
// -----------------------------------------------------------------------------
module tb_fifo_write_arbiter;
  localparam int NREQ = 4;
  localparam int DSIZE = 8;
  localparam int MAX_BURST = 4;

  logic        wclk = 1'b0;
  logic        wrst = 1'b1;
  logic [1:0]  grant_id, grant_id4;
  logic        busy, busy4;
  logic [15:0] xfer_count;
  logic [3:0]  xfer_count4;

  fifo_write_arbiter_if #(.NREQ(NREQ), .DSIZE(DSIZE)) bus ();
  fifo_write_arbiter_if #(.NREQ(NREQ), .DSIZE(DSIZE)) bus4 ();

  assign bus4.req_valid = bus.req_valid;
  assign bus4.req_last  = bus.req_last;
  assign bus4.req_data  = bus.req_data;
  assign bus4.wfull     = bus.wfull;

  fifo_write_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .MAX_BURST(MAX_BURST), .CWIDTH(16)) dut (
    .wclk(wclk), .wrst(wrst), .bus(bus),
    .grant_id(grant_id), .busy(busy), .xfer_count(xfer_count)
  );

  fifo_write_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .MAX_BURST(MAX_BURST), .CWIDTH(4)) dut4 (
    .wclk(wclk), .wrst(wrst), .bus(bus4),
    .grant_id(grant_id4), .busy(busy4), .xfer_count(xfer_count4)
  );

  always #5 wclk = ~wclk;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [7:0] src_data [NREQ][64];
  logic       src_last [NREQ][64];
  int         src_head [NREQ];
  int         src_tail [NREQ];
  logic [NREQ-1:0] gap;
  logic       wfull_drv;
  int         checks = 0;
  int         failures = 0;

  task automatic load_src(input int id, input logic [7:0] d, input logic l);
    src_data[id][src_tail[id]] = d;
    src_last[id][src_tail[id]] = l;
    src_tail[id]++;
  endtask

  task automatic expect_beat(input int id, input logic [7:0] d);
    exp_t e;
    e.id = 2'(id);
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic clear_src();
    for (int i = 0; i < NREQ; i++) begin
      src_head[i] = 0;
      src_tail[i] = 0;
    end
    gap = '0;
    wfull_drv = 1'b0;
  endtask

  task automatic drive_inputs();
    logic [NREQ-1:0]       v, l;
    logic [NREQ*DSIZE-1:0] d;
    v = '0; l = '0; d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (src_head[i] < src_tail[i]) begin
        d[i*DSIZE +: DSIZE] = src_data[i][src_head[i]];
        l[i] = src_last[i][src_head[i]];
        v[i] = !gap[i];
      end
    end
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_data  = d;
    bus.wfull     = wfull_drv;
  endtask

  // Called at a negedge; returns at the next negedge with new inputs applied
  // just after the intervening posedge.
  task automatic tick();
    logic [NREQ-1:0] hs;
    hs = bus.req_valid & bus.req_ready;
    @(posedge wclk);
    #1;
    for (int i = 0; i < NREQ; i++) if (hs[i]) src_head[i]++;
    drive_inputs();
    @(negedge wclk);
  endtask

  // Scoreboard monitor
  always @(negedge wclk) begin
    if (wrst === 1'b1) begin
      checks++;
      if (bus.winc === 1'b1 && bus.wfull === 1'b1) begin
        failures++;
        $display("FAIL overflow_guard winc=%b wfull=%b required winc=0", bus.winc, bus.wfull);
      end
      if (bus.winc === 1'b1) begin
        $display("beat grant=%0d wdata=%02h xfer_count=%0d", grant_id, bus.wdata, xfer_count);
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_beat got grant=%0d wdata=%02h required no beat", grant_id, bus.wdata);
        end else begin
          mon_e = sb.pop_front();
          if (bus.wdata !== mon_e.data || grant_id !== mon_e.id) begin
            failures++;
            $display("FAIL scoreboard got grant=%0d wdata=%02h required grant=%0d wdata=%02h",
                     grant_id, bus.wdata, mon_e.id, mon_e.data);
          end
        end
      end
    end
  end

  task automatic test_reset();
    clear_src();
    drive_inputs();
    #2 wrst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || bus.winc !== 1'b0 || bus.req_ready !== 4'b0000 ||
        grant_id !== 2'd0 || xfer_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_state got busy=%b winc=%b ready=%b grant=%0d xfer=%0d required 0,0,0000,0,0",
               busy, bus.winc, bus.req_ready, grant_id, xfer_count);
    end
    @(negedge wclk);
    @(negedge wclk);
    wrst = 1'b1;
  endtask

  task automatic test_round_robin();
    int seq [5];
    int ngr, seg, idle, exp_seq;
    logic prev_busy;
    for (int i = 0; i < NREQ; i++)
      for (int b = 0; b < 8; b++) load_src(i, 8'(i*16 + b), 1'b0);
    for (int i = 0; i < NREQ; i++)
      for (int b = 0; b < 4; b++) expect_beat(i, 8'(i*16 + b));
    expect_beat(0, 8'h04);
    expect_beat(0, 8'h05);
    ngr = 0; seg = 0; idle = 0; prev_busy = 1'b0;
    for (int c = 0; c < 200 && ngr < 5; c++) begin
      tick();
      if (busy && !prev_busy) begin
        if (ngr > 0) begin
          checks++;
          if (idle != 1) begin
            failures++;
            $display("FAIL rr_bubble got %0d idle cycles required 1", idle);
          end
        end
        seq[ngr] = int'(grant_id);
        ngr++;
        seg = 0;
      end
      if (!busy && prev_busy) begin
        checks++;
        if (seg != MAX_BURST) begin
          failures++;
          $display("FAIL rr_burst_len got %0d beats required %0d", seg, MAX_BURST);
        end
      end
      if (busy && bus.winc) seg++;
      idle = busy ? 0 : idle + 1;
      prev_busy = busy;
    end
    checks++;
    if (ngr != 5) begin
      failures++;
      $display("FAIL rr_timeout got %0d grants required 5", ngr);
    end else begin
      for (int g = 0; g < 5; g++) begin
        exp_seq = g % NREQ;
        checks++;
        if (seq[g] != exp_seq) begin
          failures++;
          $display("FAIL rr_order grant #%0d got %0d required %0d", g, seq[g], exp_seq);
        end
      end
      checks++;
      if (xfer_count !== 16'd16) begin
        failures++;
        $display("FAIL rr_xfer_count got %0d required 16", xfer_count);
      end
    end
  endtask

  task automatic test_reset_midburst();
    tick();
    checks++;
    if (bus.winc !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL midburst_active got winc=%b busy=%b required 1,1", bus.winc, busy);
    end
    #2 wrst = 1'b0;
    #1;
    checks++;
    if (bus.winc !== 1'b0 || busy !== 1'b0 || bus.req_ready !== 4'b0000) begin
      failures++;
      $display("FAIL async_reset got winc=%b busy=%b ready=%b required 0,0,0000",
               bus.winc, busy, bus.req_ready);
    end
    sb.delete();
    clear_src();
    drive_inputs();
    @(negedge wclk);
    @(negedge wclk);
    wrst = 1'b1;
    #1;
    checks++;
    if (xfer_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_xfer_count got %0d required 0", xfer_count);
    end
    for (int i = 0; i < NREQ; i++) begin
      load_src(i, 8'(8'hC0 + i), 1'b1);
      expect_beat(i, 8'(8'hC0 + i));
    end
    @(negedge wclk);
    for (int c = 0; c < 20 && !busy; c++) tick();
    checks++;
    if (busy !== 1'b1 || grant_id !== 2'd0) begin
      failures++;
      $display("FAIL first_grant got busy=%b grant=%0d required 1,0", busy, grant_id);
    end
    for (int c = 0; c < 100 && sb.size() != 0; c++) tick();
    for (int c = 0; c < 20 && busy; c++) tick();
    checks++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_drain got pending=%0d busy=%b required 0,0", sb.size(), busy);
    end
  endtask

  task automatic test_early_last();
    int beats;
    logic [7:0] got [2];
    load_src(2, 8'hA1, 1'b0);
    load_src(2, 8'hA2, 1'b1);
    expect_beat(2, 8'hA1);
    expect_beat(2, 8'hA2);
    beats = 0;
    for (int c = 0; c < 50 && beats < 2; c++) begin
      tick();
      if (busy && bus.winc) begin
        got[beats] = bus.wdata;
        beats++;
      end
    end
    checks++;
    if (beats != 2 || got[0] !== 8'hA1 || got[1] !== 8'hA2) begin
      failures++;
      $display("FAIL early_last_data got beats=%0d d0=%02h d1=%02h required 2,a1,a2", beats, got[0], got[1]);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL early_last_release got busy=%b required 0", busy);
    end
  endtask

  task automatic test_backpressure();
    int beats;
    for (int b = 0; b < 5; b++) begin
      load_src(1, 8'(8'h55 + b), (b == 4));
      expect_beat(1, 8'(8'h55 + b));
    end
    beats = 0;
    for (int c = 0; c < 50 && beats < 2; c++) begin
      tick();
      if (busy && bus.winc) beats++;
    end
    wfull_drv = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (bus.winc !== 1'b0 || bus.req_ready[1] !== 1'b0 || busy !== 1'b1 || grant_id !== 2'd1) begin
        failures++;
        $display("FAIL backpressure_stall cycle %0d got winc=%b ready1=%b busy=%b grant=%0d required 0,0,1,1",
                 k, bus.winc, bus.req_ready[1], busy, grant_id);
      end
    end
    wfull_drv = 1'b0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (!busy) break;
      if (bus.winc) beats++;
    end
    checks++;
    if (beats != MAX_BURST || busy !== 1'b0) begin
      failures++;
      $display("FAIL backpressure_burst got beats=%0d busy=%b required %0d,0", beats, busy, MAX_BURST);
    end
    for (int c = 0; c < 50 && sb.size() != 0; c++) tick();
    for (int c = 0; c < 20 && busy; c++) tick();
  endtask

  task automatic test_valid_gap();
    int beats;
    for (int b = 0; b < 4; b++) begin
      load_src(3, 8'(8'hD0 + b), 1'b0);
      expect_beat(3, 8'(8'hD0 + b));
    end
    load_src(0, 8'hE0, 1'b1);
    expect_beat(0, 8'hE0);
    beats = 0;
    for (int c = 0; c < 50 && beats < 2; c++) begin
      tick();
      if (busy && bus.winc) beats++;
    end
    gap[3] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (busy !== 1'b1 || grant_id !== 2'd3 || bus.winc !== 1'b0 || bus.req_ready[0] !== 1'b0) begin
        failures++;
        $display("FAIL valid_gap_hold cycle %0d got busy=%b grant=%0d winc=%b ready0=%b required 1,3,0,0",
                 k, busy, grant_id, bus.winc, bus.req_ready[0]);
      end
    end
    gap[3] = 1'b0;
    for (int c = 0; c < 100 && sb.size() != 0; c++) tick();
    for (int c = 0; c < 20 && busy; c++) tick();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL valid_gap_drain got pending=%0d required 0", sb.size());
    end
  endtask

  task automatic test_counter_wrap();
    #2 wrst = 1'b0;
    sb.delete();
    clear_src();
    drive_inputs();
    @(negedge wclk);
    @(negedge wclk);
    wrst = 1'b1;
    for (int b = 0; b < 17; b++) begin
      load_src(0, 8'(8'h20 + b), (b == 16));
      expect_beat(0, 8'(8'h20 + b));
    end
    for (int c = 0; c < 200 && sb.size() != 0; c++) tick();
    for (int c = 0; c < 20 && busy; c++) tick();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL wrap_drain got pending=%0d required 0", sb.size());
    end
    checks++;
    if (xfer_count4 !== 4'd1 || xfer_count !== 16'd17) begin
      failures++;
      $display("FAIL counter_wrap got xfer4=%0d xfer16=%0d required 1,17", xfer_count4, xfer_count);
    end
    checks++;
    if (busy4 !== 1'b0 || grant_id4 !== 2'd0) begin
      failures++;
      $display("FAIL wrap_instance_state got busy4=%b grant4=%0d required 0,0", busy4, grant_id4);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_reset_midburst();
    test_early_last();
    test_backpressure();
    test_valid_gap();
    test_counter_wrap();
    #20;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
